// File: rtl/sim_mailbox_pkg.sv
// sim_mailbox_pkg: register offsets and bit positions for the host mailbox
package sim_mailbox_pkg;
  localparam logic [3:0] OFF_RXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam int ST_EMPTY    = 16;
  localparam int ST_FULL     = 17;
  localparam int ST_UNDER    = 18;
  localparam int ST_DROP     = 19;
  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_EN     = 1;
  localparam int CTRL_IRQ_EN = 2;
endpackage

// File: rtl/sim_mailbox_fifo.sv
// sim_mailbox_fifo: synchronous FIFO with combinational head, flush wins over push/pop
module sim_mailbox_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sim_clk,
  input  logic                  sim_rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);
  logic [31:0]           mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  assign dout  = mem_q[rptr_q];
  assign count = count_q;
  assign empty = count_q == '0;
  assign full  = count_q[DEPTH_LOG2];
  // pointers wrap modulo depth; caller guarantees no push when full, no pop when empty
  always_ff @(posedge sim_clk or posedge sim_rst)
    if (sim_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + DEPTH_LOG2'(1);
      if (pop) rptr_q <= rptr_q + DEPTH_LOG2'(1);
      count_q <= count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end
  // storage has no reset; a flushed push is dropped
  always_ff @(posedge sim_clk)
    if (push && !flush) mem_q[wptr_q] <= din;
endmodule

// File: rtl/sim_host_mailbox.sv
// sim_host_mailbox: host-to-CPU word mailbox on the tawas bus (optional IRQ via SIM_MAILBOX_IRQ_EN)
module sim_host_mailbox
  import sim_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFFFFE0,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        sim_clk,
  input  logic        sim_rst,
  input  logic [31:0] ADDR,
  input  logic        CS,
  input  logic        WR,
  input  logic [3:0]  MASK,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  input  logic        HOST_VALID,
  input  logic [31:0] HOST_DATA,
  output logic        HOST_READY
`ifdef SIM_MAILBOX_IRQ_EN
  ,
  output logic        IRQ
`endif
);
`ifdef SIM_MAILBOX_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  logic                sel, rx_rd, st_wr, ctrl_wr, push, pop, flush;
  logic [3:0]          off;
  logic [31:0]         head, status, ctrl_rd;
  logic [DEPTH_LOG2:0] count;
  logic                empty, full;
  logic                en_q, en_d, irq_en_q, irq_en_d, under_q, under_d, drop_q, drop_d;
  logic [31:0]         dout_q, dout_d;
  logic                unused;
  assign sel        = CS && ADDR[31:4] == BASE_ADDR[31:4];
  assign off        = {ADDR[3:2], 2'b00};
  assign rx_rd      = sel && !WR && off == OFF_RXDATA;
  assign st_wr      = sel && WR && off == OFF_STATUS && MASK[2];
  assign ctrl_wr    = sel && WR && off == OFF_CTRL && MASK[0];
  assign HOST_READY = en_q && !full;
  assign push       = HOST_VALID && HOST_READY;
  assign pop        = rx_rd && !empty;
  assign flush      = ctrl_wr && DIN[CTRL_FLUSH];
  assign status     = {12'd0, drop_q, under_q, full, empty, 16'(count)};
  assign ctrl_rd    = {29'd0, irq_en_q, en_q, 1'b0};
  assign DOUT       = dout_q;
  assign unused     = &{1'b0, ADDR[1:0], MASK[3], MASK[1], DIN[31:20], DIN[17:3], DIN[CTRL_IRQ_EN]};
  sim_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .sim_clk (sim_clk),
    .sim_rst (sim_rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (HOST_DATA),
    .dout    (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );
  // next state: control bits, stickies (set beats clear) and read data mux
  always_comb begin
    en_d     = ctrl_wr ? DIN[CTRL_EN] : en_q;
    irq_en_d = ctrl_wr ? DIN[CTRL_IRQ_EN] && IRQ_ON : irq_en_q;
    under_d  = (rx_rd && empty) || (under_q && !(st_wr && DIN[ST_UNDER]));
    drop_d   = (HOST_VALID && !en_q) || (drop_q && !(st_wr && DIN[ST_DROP]));
    dout_d   = !(sel && !WR)         ? '0 :
               off == OFF_RXDATA     ? (empty ? '0 : head) :
               off == OFF_STATUS     ? status :
               off == OFF_CTRL       ? ctrl_rd : '0;
  end
  // register state, asynchronous reset clears everything
  always_ff @(posedge sim_clk or posedge sim_rst)
    if (sim_rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      under_q  <= 1'b0;
      drop_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      under_q  <= under_d;
      drop_q   <= drop_d;
      dout_q   <= dout_d;
    end
`ifdef SIM_MAILBOX_IRQ_EN
  logic irq_q;
  assign IRQ = irq_q;
  // interrupt follows the FIFO state one edge later
  always_ff @(posedge sim_clk or posedge sim_rst)
    if (sim_rst) irq_q <= 1'b0;
    else irq_q <= irq_en_q && !empty;
`endif
endmodule

// File: tb/tb_sim_host_mailbox.sv
// tb_sim_host_mailbox: scoreboard bench with a queue-based reference model
module tb_sim_host_mailbox;
  localparam logic [31:0] BASE = 32'hFFFFFFE0;
  logic        sim_clk = 1'b0;
  logic        sim_rst = 1'b1;
  logic [31:0] ADDR, DIN, DOUT, HOST_DATA;
  logic        CS, WR, HOST_VALID, HOST_READY;
  logic [3:0]  MASK;
`ifdef SIM_MAILBOX_IRQ_EN
  logic        IRQ;
`endif
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] fifo_m[$];
  bit          en_m, irqen_m, under_m, drop_m, irq_m;

  sim_host_mailbox dut (
    .sim_clk    (sim_clk),
    .sim_rst    (sim_rst),
    .ADDR       (ADDR),
    .CS         (CS),
    .WR         (WR),
    .MASK       (MASK),
    .DIN        (DIN),
    .DOUT       (DOUT),
    .HOST_VALID (HOST_VALID),
    .HOST_DATA  (HOST_DATA),
    .HOST_READY (HOST_READY)
`ifdef SIM_MAILBOX_IRQ_EN
    ,
    .IRQ        (IRQ)
`endif
  );

  always #5 sim_clk = ~sim_clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] status_m();
    return {12'd0, drop_m, under_m, fifo_m.size() == 16, fifo_m.size() == 0, 16'(fifo_m.size())};
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    {en_m, irqen_m, under_m, drop_m, irq_m} = '0;
  endtask

  task automatic cyc(input bit cs, input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] din, input bit hv, input logic [31:0] hd);
    bit sel, ready, flush;
    logic [3:0] off;
    CS = cs; WR = wr; ADDR = addr; MASK = mask; DIN = din; HOST_VALID = hv; HOST_DATA = hd;
    ready = en_m && fifo_m.size() < 16;
    chk("host_ready", 32'(HOST_READY), 32'(ready));
`ifdef SIM_MAILBOX_IRQ_EN
    chk("irq", 32'(IRQ), 32'(irq_m));
    irq_m = irqen_m && fifo_m.size() != 0;
`endif
    sel = cs && addr[31:4] == BASE[31:4];
    off = {addr[3:2], 2'b00};
    flush = sel && wr && off == 4'h8 && mask[0] && din[0];
    if (sel && !wr) begin
      if (off == 4'h0) begin
        if (fifo_m.size() != 0) exp_q.push_back(fifo_m.pop_front());
        else begin
          exp_q.push_back(32'd0);
          under_m = 1'b1;
        end
      end else if (off == 4'h4) exp_q.push_back(status_m());
      else if (off == 4'h8) exp_q.push_back({29'd0, irqen_m, en_m, 1'b0});
      else exp_q.push_back(32'd0);
    end
    if (sel && wr && off == 4'h4 && mask[2]) begin
      if (din[18]) under_m = 1'b0;
      if (din[19]) drop_m = 1'b0;
    end
    if (hv && !en_m) drop_m = 1'b1;
    if (hv && ready && !flush) fifo_m.push_back(hd);
    if (flush) fifo_m.delete();
    if (sel && wr && off == 4'h8 && mask[0]) begin
      en_m = din[1];
`ifdef SIM_MAILBOX_IRQ_EN
      irqen_m = din[2];
`endif
    end
    @(negedge sim_clk);
  endtask

  task automatic rd(input logic [3:0] off);
    cyc(1'b1, 1'b0, BASE | 32'(off), 4'h0, 32'd0, 1'b0, 32'd0);
  endtask
  task automatic wrr(input logic [3:0] off, input logic [3:0] mask, input logic [31:0] d);
    cyc(1'b1, 1'b1, BASE | 32'(off), mask, d, 1'b0, 32'd0);
  endtask
  task automatic push(input logic [31:0] d);
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, d);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0, 32'd0);
  endtask

  // monitor: one edge after a selected read DOUT carries data, otherwise it must be 0
  initial forever begin
    bit pend;
    @(posedge sim_clk);
    pend = !sim_rst && CS && !WR && ADDR[31:4] == BASE[31:4];
    @(negedge sim_clk);
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout: unexpected read data %h with nothing expected", DOUT);
      end else chk("dout", DOUT, exp_q.pop_front());
    end else chk("dout_idle", DOUT, 32'd0);
  end

  initial begin
    int r;
    bit hv;
    logic [31:0] d;
    {CS, WR, HOST_VALID} = '0;
    ADDR = '0; MASK = '0; DIN = '0; HOST_DATA = '0;
    model_reset();
    repeat (2) @(negedge sim_clk);
    sim_rst = 1'b0;
    chk("rst_dout", DOUT, 32'd0);
    chk("rst_ready", 32'(HOST_READY), 32'd0);
    rd(4'h4);
    wrr(4'h8, 4'hF, 32'h2);
    push(32'h11111111);
    push(32'h22222222);
    rd(4'h4);
    rd(4'h0);
    rd(4'h0);
    rd(4'h4);
    for (int i = 0; i < 16; i++) push($urandom);
    rd(4'h4);
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, 32'hDEADBEEF);
    rd(4'h0);
    for (int i = 0; i < 16; i++) rd(4'h0);
    rd(4'h4);
    wrr(4'h4, 4'h4, 32'h00040000);
    rd(4'h4);
    wrr(4'h8, 4'hF, 32'h0);
    push(32'h33333333);
    rd(4'h4);
    wrr(4'h4, 4'h4, 32'h00080000);
    wrr(4'h8, 4'h0, 32'h0);
    rd(4'h8);
    wrr(4'h8, 4'hF, 32'h2);
    for (int i = 0; i < 3; i++) push($urandom);
    cyc(1'b1, 1'b1, BASE | 32'h8, 4'hF, 32'h3, 1'b1, 32'h44444444);
    rd(4'h4);
    rd(4'h8);
    rd(4'hC);
    cyc(1'b1, 1'b1, 32'hFFFFFFD8, 4'hF, 32'h0, 1'b0, 32'd0);
    rd(4'h8);
`ifdef SIM_MAILBOX_IRQ_EN
    wrr(4'h8, 4'hF, 32'h6);
    push(32'h55555555);
    idle();
    idle();
    rd(4'h0);
    idle();
    idle();
`endif
    push(32'h66666666);
    push(32'h77777777);
    #3 sim_rst = 1'b1;
    #1;
    chk("async_rst_dout", DOUT, 32'd0);
    chk("async_rst_ready", 32'(HOST_READY), 32'd0);
    model_reset();
    @(negedge sim_clk);
    sim_rst = 1'b0;
    rd(4'h4);
    wrr(4'h8, 4'hF, 32'h2);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      hv = $urandom_range(0, 9) < 6;
      if (r < 40) cyc(1'b1, 1'b0, BASE | ($urandom & 32'h3), 4'($urandom), 32'd0, hv, $urandom);
      else if (r < 58) cyc(1'b1, 1'b0, BASE | ($urandom & 32'hF), 4'($urandom), 32'd0, hv, $urandom);
      else if (r < 63) cyc(1'b1, 1'b0, 32'hFFFFFFD0 | ($urandom & 32'hF), 4'hF, 32'd0, hv, $urandom);
      else if (r < 70) cyc(1'b1, 1'b1, BASE | 32'h4 | ($urandom & 32'h3), 4'($urandom), $urandom, hv, $urandom);
      else if (r < 76) begin
        d = ($urandom_range(0, 7) == 0 ? 32'h0 : 32'h2) | ($urandom & 32'h4) |
            ($urandom_range(0, 9) == 0 ? 32'h1 : 32'h0);
        cyc(1'b1, 1'b1, BASE | 32'h8, 4'($urandom) | 4'h1, d, hv, $urandom);
      end else if (r < 80) cyc(1'b1, 1'b1, ($urandom_range(0, 1) == 0 ? BASE | 32'hC : 32'hFFFFFFD8),
                               4'hF, $urandom, hv, $urandom);
      else cyc(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, hv, $urandom);
    end
    idle();
    idle();
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
